gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_pkg.sv | 30 +++
 rtl/gray_to_bin.sv | 20 ++
 rtl/gray_counter.sv | 104 ++++++++++
 tb/tb_gray_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : gray_pkg
//  Brief   : Shared Gray/binary conversion helpers and wrap-mode constants
//            for the gray_counter block.
//  Rev     : 1.0  initial release
// ============================================================================
package gray_pkg;

  // Values for the gray_counter WRAP parameter
  localparam int unsigned WRAP_MODE = 1;
  localparam int unsigned SAT_MODE  = 0;

  // Binary to reflected Gray code; narrower values are zero-extended by the caller
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
//  Module  : gray_to_bin
//  Brief   : Combinational Gray-to-binary converter, WIDTH bits (2..32).
//  Rev     : 1.0  initial release
// ============================================================================
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Zero-extend into the 32-bit helper; upper zeros decode to zeros
  assign bin = WIDTH'(gray2bin(32'(gray)));

endmodule : gray_to_bin
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module  : gray_counter
//  Brief   : Up/down counter with registered binary and Gray outputs, a
//            synchronous load, wrap or saturate behaviour and a one-cycle
//            wrap pulse.
//            Build option: GRAY_COUNTER_LOAD_GRAY_EN -- when defined, load_val
//            is Gray coded and decoded by gray_to_bin before the register;
//            otherwise load_val is plain binary.
//  Rev     : 1.0  initial release
// ============================================================================
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned WRAP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_max        = '1;
  localparam logic [WIDTH-1:0] c_reset_bin  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_reset_gray = WIDTH'(bin2gray(RESET_VAL));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_wrap_nxt;

`ifdef GRAY_COUNTER_LOAD_GRAY_EN
  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_gray_to_bin (
    .gray (load_val),
    .bin  (w_load_bin)
  );
`else
  assign w_load_bin = load_val;
`endif

  // Next-state count: load beats enable; the boundary either wraps (with a pulse) or holds
  always_comb begin
    w_bin_nxt  = r_bin;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_bin_nxt = w_load_bin;
    end else if (en) begin
      if (up) begin
        if (r_bin == c_max) begin
          if (WRAP == WRAP_MODE) begin
            w_bin_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_bin_nxt = r_bin + c_one;
        end
      end else begin
        if (r_bin == '0) begin
          if (WRAP == WRAP_MODE) begin
            w_bin_nxt  = c_max;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_bin_nxt = r_bin - c_one;
        end
      end
    end
    // Gray is derived from the next binary state so both registers move on the same edge
    w_gray_nxt = WIDTH'(bin2gray(32'(w_bin_nxt)));
  end

  // State registers with asynchronous reset to the configured start value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= c_reset_bin;
      r_gray <= c_reset_gray;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign wrap = r_wrap;

endmodule : gray_counter
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_gray_counter
//  Brief   : Self-checking bench for gray_counter: a wrapping WIDTH=4 counter
//            (RESET_VAL=5), a saturating WIDTH=4 counter and a WIDTH=8 counter
//            exercised with a mid-cycle reset pulse.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_gray_counter;

  logic clk;

  // Wrapping counter, WIDTH=4, RESET_VAL=5
  logic       a_rst_n, a_en, a_up, a_load, a_wrap;
  logic [3:0] a_lv, a_bin, a_gray;
  // Saturating counter, WIDTH=4, RESET_VAL=0
  logic       s_rst_n, s_en, s_up, s_load, s_wrap;
  logic [3:0] s_lv, s_bin, s_gray;
  // Wrapping counter, WIDTH=8, RESET_VAL=0x3C
  logic       w_rst_n, w_en, w_up, w_load, w_wrap;
  logic [7:0] w_lv, w_bin, w_gray;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lval;
    logic [3:0] ebin;
    logic [3:0] egray;
    logic       ewrap;
  } vec_t;

  vec_t tbl[40];
  int   n_vec;

  gray_counter #(.WIDTH(4), .RESET_VAL(5), .WRAP(1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .bin(a_bin), .gray(a_gray), .wrap(a_wrap)
  );

  gray_counter #(.WIDTH(4), .RESET_VAL(0), .WRAP(0)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .en(s_en), .up(s_up), .load(s_load),
    .load_val(s_lv), .bin(s_bin), .gray(s_gray), .wrap(s_wrap)
  );

  gray_counter #(.WIDTH(8), .RESET_VAL(8'h3C), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .en(w_en), .up(w_up), .load(w_load),
    .load_val(w_lv), .bin(w_bin), .gray(w_gray), .wrap(w_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encode a binary load value the way the current build expects it
  function automatic logic [31:0] lv(input logic [31:0] b);
`ifdef GRAY_COUNTER_LOAD_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic e, input logic u, input logic [3:0] lval,
                     input logic [3:0] eb, input logic [3:0] eg, input logic ew);
    tbl[n_vec].load  = ld;
    tbl[n_vec].en    = e;
    tbl[n_vec].up    = u;
    tbl[n_vec].lval  = lval;
    tbl[n_vec].ebin  = eb;
    tbl[n_vec].egray = eg;
    tbl[n_vec].ewrap = ew;
    n_vec++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] prev_bin, prev_gray;
    n_checks = 0;
    n_fail   = 0;
    n_vec    = 0;

    // Hold with enable low, then load 0 with enable high (load wins)
    add(0,0,1,4'h0, 4'h5,4'h7,0);
    add(0,0,0,4'h0, 4'h5,4'h7,0);
    add(0,0,1,4'h0, 4'h5,4'h7,0);
    add(1,1,1,4'h0, 4'h0,4'h0,0);
    // Full up-count cycle, wrap pulse on return to 0
    add(0,1,1,4'h0, 4'h1,4'h1,0);
    add(0,1,1,4'h0, 4'h2,4'h3,0);
    add(0,1,1,4'h0, 4'h3,4'h2,0);
    add(0,1,1,4'h0, 4'h4,4'h6,0);
    add(0,1,1,4'h0, 4'h5,4'h7,0);
    add(0,1,1,4'h0, 4'h6,4'h5,0);
    add(0,1,1,4'h0, 4'h7,4'h4,0);
    add(0,1,1,4'h0, 4'h8,4'hC,0);
    add(0,1,1,4'h0, 4'h9,4'hD,0);
    add(0,1,1,4'h0, 4'hA,4'hF,0);
    add(0,1,1,4'h0, 4'hB,4'hE,0);
    add(0,1,1,4'h0, 4'hC,4'hA,0);
    add(0,1,1,4'h0, 4'hD,4'hB,0);
    add(0,1,1,4'h0, 4'hE,4'h9,0);
    add(0,1,1,4'h0, 4'hF,4'h8,0);
    add(0,1,1,4'h0, 4'h0,4'h0,1);
    // Loads: value A, then F, then a jump F->0 that must not pulse wrap
    add(1,1,1,4'hA, 4'hA,4'hF,0);
    add(1,0,0,4'hF, 4'hF,4'h8,0);
    add(1,1,1,4'h0, 4'h0,4'h0,0);
    // Down through zero, then alternate direction across the boundary
    add(1,0,0,4'h1, 4'h1,4'h1,0);
    add(0,1,0,4'h0, 4'h0,4'h0,0);
    add(0,1,0,4'h0, 4'hF,4'h8,1);
    add(0,1,1,4'h0, 4'h0,4'h0,1);
    add(0,1,0,4'h0, 4'hF,4'h8,1);
    add(0,1,1,4'h0, 4'h0,4'h0,1);
    // Idle clears wrap; direction flip takes effect immediately
    add(0,0,0,4'h0, 4'h0,4'h0,0);
    add(0,1,1,4'h0, 4'h1,4'h1,0);
    add(0,1,0,4'h0, 4'h0,4'h0,0);

    a_rst_n = 1'b1; s_rst_n = 1'b1; w_rst_n = 1'b1;
    a_en = 0; a_up = 0; a_load = 0; a_lv = '0;
    s_en = 0; s_up = 0; s_load = 0; s_lv = '0;
    w_en = 0; w_up = 0; w_load = 0; w_lv = '0;

    // Asynchronous reset: values appear before any clock edge
    #1;
    a_rst_n = 1'b0; s_rst_n = 1'b0; w_rst_n = 1'b0;
    #1;
    check("rst_a_bin",  32'(a_bin),  32'h5);
    check("rst_a_gray", 32'(a_gray), 32'h7);
    check("rst_a_wrap", 32'(a_wrap), 32'h0);
    check("rst_s_bin",  32'(s_bin),  32'h0);
    check("rst_w_bin",  32'(w_bin),  32'h3C);
    check("rst_w_gray", 32'(w_gray), 32'h22);
    @(negedge clk);
    @(negedge clk);
    a_rst_n = 1'b1; s_rst_n = 1'b1; w_rst_n = 1'b1;

    // Table-driven run on the wrapping 4-bit counter
    prev_bin  = a_bin;
    prev_gray = a_gray;
    for (int i = 0; i < n_vec; i++) begin
      a_load = tbl[i].load;
      a_en   = tbl[i].en;
      a_up   = tbl[i].up;
      a_lv   = 4'(lv(32'(tbl[i].lval)));
      step();
      check($sformatf("a_bin[%0d]", i),  32'(a_bin),  32'(tbl[i].ebin));
      check($sformatf("a_gray[%0d]", i), 32'(a_gray), 32'(tbl[i].egray));
      check($sformatf("a_wrap[%0d]", i), 32'(a_wrap), 32'(tbl[i].ewrap));
      if (!tbl[i].load && tbl[i].en && (tbl[i].ebin != prev_bin))
        check($sformatf("a_onebit[%0d]", i), 32'($countones(a_gray ^ prev_gray)), 32'd1);
      prev_bin  = a_bin;
      prev_gray = a_gray;
    end
    a_en = 0; a_load = 0;

    // Saturating counter: hold at the top, then hold at zero
    s_load = 1; s_en = 0; s_lv = 4'(lv(32'hF));
    step();
    check("s_load_bin", 32'(s_bin), 32'hF);
    s_load = 0; s_en = 1; s_up = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("s_top_bin[%0d]", i),  32'(s_bin),  32'hF);
      check($sformatf("s_top_gray[%0d]", i), 32'(s_gray), 32'h8);
      check($sformatf("s_top_wrap[%0d]", i), 32'(s_wrap), 32'h0);
    end
    s_up = 0;
    step();
    check("s_dn_bin",  32'(s_bin),  32'hE);
    check("s_dn_gray", 32'(s_gray), 32'h9);
    s_load = 1; s_lv = 4'(lv(32'h0));
    step();
    s_load = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("s_bot_bin[%0d]", i),  32'(s_bin),  32'h0);
      check($sformatf("s_bot_wrap[%0d]", i), 32'(s_wrap), 32'h0);
    end
    s_up = 1;
    step();
    check("s_up_bin", 32'(s_bin), 32'h1);
    s_en = 0;

    // 8-bit counter: wrap, then a reset pulse between clock edges
    w_load = 1; w_lv = 8'(lv(32'hFE));
    step();
    check("w_load_bin",  32'(w_bin),  32'hFE);
    check("w_load_gray", 32'(w_gray), 32'h81);
    w_load = 0; w_en = 1; w_up = 1;
    step();
    check("w_ff_bin",  32'(w_bin),  32'hFF);
    check("w_ff_gray", 32'(w_gray), 32'h80);
    @(posedge clk);
    #1;
    check("w_wrap_bin",   32'(w_bin),  32'h00);
    check("w_wrap_pulse", 32'(w_wrap), 32'h1);
    #1;
    w_rst_n = 1'b0;
    #1;
    check("w_midrst_bin",  32'(w_bin),  32'h3C);
    check("w_midrst_gray", 32'(w_gray), 32'h22);
    check("w_midrst_wrap", 32'(w_wrap), 32'h0);
    #1;
    w_rst_n = 1'b1;
    @(negedge clk);
    check("w_rel_bin",  32'(w_bin),  32'h3C);
    check("w_rel_wrap", 32'(w_wrap), 32'h0);
    step();
    check("w_resume_bin",  32'(w_bin),  32'h3D);
    check("w_resume_gray", 32'(w_gray), 32'h23);
    check("w_resume_wrap", 32'(w_wrap), 32'h0);
    step();
    check("w_next_bin",  32'(w_bin),  32'h3E);
    check("w_next_gray", 32'(w_gray), 32'h21);
    w_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gray_counter
`default_nettype wire
